// File: rtl/lock_pkg.sv
// Shared state encoding and parameter defaults for the keypad lockout controller.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_LOCKOUT = 2'd1,
    ST_ALARM   = 2'd2
  } lock_state_e;

  localparam int DEF_CLK_HZ       = 100_000_000;
  localparam int DEF_MAX_FAIL     = 3;
  localparam int DEF_LOCKOUT_SEC  = 30;
  localparam int DEF_MAX_LOCKOUTS = 2;

endpackage

// File: rtl/tick_gen.sv
// Half-second prescaler: blink is a 1 Hz square wave, sec_tick fires on its falling edge.
module tick_gen
  import lock_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic blink,
  output logic sec_tick
);

  localparam int HALF = CLK_HZ / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = (cnt == CW'(HALF - 1));
  assign sec_tick = wrap & blink;

  // count 0..HALF-1, toggle blink on every wrap; restart realigns the second boundary
  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      blink <= ~blink;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lockout_ctrl.sv
// Button edge gating plus failed-attempt lockout / alarm state machine.
module lockout_ctrl
  import lock_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int MAX_FAIL     = DEF_MAX_FAIL,
  parameter int LOCKOUT_SEC  = DEF_LOCKOUT_SEC,
  parameter int MAX_LOCKOUTS = DEF_MAX_LOCKOUTS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ent,
  input  logic       clr,
  input  logic       change,
  input  logic       check_valid,
  input  logic       check_pass,
  output logic       ent_p,
  output logic       clr_p,
  output logic       change_p,
  output logic       lockout,
  output logic       alarm,
  output logic [1:0] fail_cnt,
  output logic [5:0] remain,
  output logic       blink
);

  lock_state_e state_q, state_d;
  logic [1:0]  fail_q, fail_d;
  logic [1:0]  lcnt_q, lcnt_d;
  logic [5:0]  remain_q, remain_d;
  logic        restart;
  logic        sec_tick;

  logic        ent_q, clr_q, chg_q;
  logic        armed;
  logic        ent_r, clr_r, chg_r, gate;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .blink    (blink),
    .sec_tick (sec_tick)
  );

  // state and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_NORMAL;
      fail_q   <= '0;
      lcnt_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      fail_q   <= fail_d;
      lcnt_q   <= lcnt_d;
      remain_q <= remain_d;
    end
  end

  // next-state: attempt accounting in NORMAL, countdown in LOCKOUT, latch in ALARM
  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    lcnt_d   = lcnt_q;
    remain_d = remain_q;
    restart  = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (check_valid) begin
          if (check_pass) begin
            fail_d = '0;
            lcnt_d = '0;
          end else if (fail_q >= 2'(MAX_FAIL - 1)) begin
            fail_d  = '0;
            lcnt_d  = lcnt_q + 2'd1;
            restart = 1'b1;
            if ((lcnt_q + 2'd1) == 2'(MAX_LOCKOUTS)) begin
              state_d  = ST_ALARM;
              remain_d = '0;
            end else begin
              state_d  = ST_LOCKOUT;
              remain_d = 6'(LOCKOUT_SEC);
            end
          end else begin
            fail_d = fail_q + 2'd1;
          end
        end
      end
      ST_LOCKOUT: begin
        if (sec_tick) begin
          if (remain_q <= 6'd1) begin
            remain_d = '0;
            state_d  = ST_NORMAL;
          end else begin
            remain_d = remain_q - 6'd1;
          end
        end
      end
      ST_ALARM: remain_d = '0;
      default: begin
        state_d  = ST_NORMAL;
        remain_d = '0;
      end
    endcase
  end

  // armed masks the first cycle after reset so a button held through reset does not pulse
  assign gate  = armed && (state_q == ST_NORMAL);
  assign ent_r = ent & ~ent_q;
  assign clr_r = clr & ~clr_q;
  assign chg_r = change & ~chg_q;

  // edge history and prioritized, gated one-cycle pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_q    <= 1'b0;
      clr_q    <= 1'b0;
      chg_q    <= 1'b0;
      armed    <= 1'b0;
      ent_p    <= 1'b0;
      clr_p    <= 1'b0;
      change_p <= 1'b0;
    end else begin
      ent_q    <= ent;
      clr_q    <= clr;
      chg_q    <= change;
      armed    <= 1'b1;
      ent_p    <= gate & ent_r;
      clr_p    <= gate & clr_r & ~ent_r;
      change_p <= gate & chg_r & ~ent_r & ~clr_r;
    end
  end

  assign lockout  = (state_q != ST_NORMAL);
  assign alarm    = (state_q == ST_ALARM);
  assign fail_cnt = fail_q;
  assign remain   = remain_q;

endmodule

// File: tb/tb_lockout_ctrl.sv
// Directed bench for lockout_ctrl with CLK_HZ=10, MAX_FAIL=3, LOCKOUT_SEC=2, MAX_LOCKOUTS=2.
module tb_lockout_ctrl;

  logic       clk = 1'b0;
  logic       rst, ent, clr, change, check_valid, check_pass;
  logic       ent_p, clr_p, change_p, lockout, alarm, blink;
  logic [1:0] fail_cnt;
  logic [5:0] remain;

  int n_tot = 0;
  int n_bad = 0;
  int pulses, errs;
  logic [3:0] pat;

  always #5 clk = ~clk;

  lockout_ctrl #(
    .CLK_HZ(10), .MAX_FAIL(3), .LOCKOUT_SEC(2), .MAX_LOCKOUTS(2)
  ) dut (
    .clk(clk), .rst(rst), .ent(ent), .clr(clr), .change(change),
    .check_valid(check_valid), .check_pass(check_pass),
    .ent_p(ent_p), .clr_p(clr_p), .change_p(change_p),
    .lockout(lockout), .alarm(alarm), .fail_cnt(fail_cnt),
    .remain(remain), .blink(blink)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic p);
    check_valid = 1'b1;
    check_pass  = p;
    @(negedge clk);
    check_valid = 1'b0;
    check_pass  = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_lockout"}, 32'(lockout), 0);
    chk({tag, "_alarm"},   32'(alarm), 0);
    chk({tag, "_fail"},    32'(fail_cnt), 0);
    chk({tag, "_remain"},  32'(remain), 0);
    chk({tag, "_blink"},   32'(blink), 0);
    chk({tag, "_pulses"},  32'({ent_p, clr_p, change_p}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ent = 1'b0; clr = 1'b0; change = 1'b0;
    check_valid = 1'b0; check_pass = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");

    // button held high across reset release must not pulse
    ent = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (4) begin @(negedge clk); pulses += int'(ent_p); end
    chk("held_thru_rst", 32'(pulses), 0);
    ent = 1'b0;
    repeat (2) @(negedge clk);

    // single ent edge held 4 cycles: pulse only in the first cycle after the edge
    ent = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); pat[i] = ent_p; end
    chk("ent_pattern", 32'(pat), 32'b0001);
    ent = 1'b0;
    @(negedge clk);

    clr = 1'b1;
    @(negedge clk); chk("clr_p_on", 32'(clr_p), 1);
    clr = 1'b0;
    @(negedge clk); chk("clr_p_off", 32'(clr_p), 0);

    change = 1'b1;
    @(negedge clk); chk("chg_p_on", 32'(change_p), 1);
    change = 1'b0;
    @(negedge clk); chk("chg_p_off", 32'(change_p), 0);

    // simultaneous edges: ent beats clr, clr beats change
    ent = 1'b1; clr = 1'b1;
    @(negedge clk);
    chk("prio_ent_p", 32'(ent_p), 1);
    chk("prio_clr_p", 32'(clr_p), 0);
    @(negedge clk);
    chk("prio_after", 32'({ent_p, clr_p, change_p}), 0);
    ent = 1'b0; clr = 1'b0;
    @(negedge clk);
    clr = 1'b1; change = 1'b1;
    @(negedge clk);
    chk("prio2_clr_p", 32'(clr_p), 1);
    chk("prio2_chg_p", 32'(change_p), 0);
    clr = 1'b0; change = 1'b0;
    @(negedge clk);

    // three fails -> lockout for exactly 20 cycles
    strobe(1'b0); chk("f1_cnt", 32'(fail_cnt), 1);
    strobe(1'b0); chk("f2_cnt", 32'(fail_cnt), 2);
    chk("f2_lockout", 32'(lockout), 0);
    strobe(1'b0);
    chk("lo_lockout", 32'(lockout), 1);
    chk("lo_alarm", 32'(alarm), 0);
    chk("lo_remain", 32'(remain), 2);
    chk("lo_fail", 32'(fail_cnt), 0);
    chk("lo_blink", 32'(blink), 0);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      ent = ~ent;
      if (i == 1) begin check_valid = 1'b1; check_pass = 1'b0; end
      @(negedge clk);
      check_valid = 1'b0;
      pulses += int'(ent_p | clr_p | change_p);
      if (i == 2)  chk("lo_ign_valid", 32'(fail_cnt), 0);
      if (i == 4)  chk("lo_blink4", 32'(blink), 0);
      if (i == 5)  chk("lo_blink5", 32'(blink), 1);
      if (i == 9)  chk("lo_rem9", 32'(remain), 2);
      if (i == 10) chk("lo_rem10", 32'(remain), 1);
      if (i == 10) chk("lo_blink10", 32'(blink), 0);
      if (i == 19) chk("lo_on19", 32'(lockout), 1);
      if (i == 19) chk("lo_rem19", 32'(remain), 1);
      if (i == 20) chk("lo_off20", 32'(lockout), 0);
      if (i == 20) chk("lo_rem20", 32'(remain), 0);
    end
    ent = 1'b0;
    @(negedge clk);
    pulses += int'(ent_p | clr_p | change_p);
    chk("lo_no_pulses", 32'(pulses), 0);

    // a pass clears fail_cnt and the lockout count; three more fails needed
    strobe(1'b0); strobe(1'b0);
    chk("p_pre", 32'(fail_cnt), 2);
    strobe(1'b1);
    chk("p_clear", 32'(fail_cnt), 0);
    strobe(1'b0); chk("p_f1", 32'(fail_cnt), 1);
    strobe(1'b0); chk("p_f2", 32'(fail_cnt), 2);
    chk("p_f2_lockout", 32'(lockout), 0);
    strobe(1'b0);
    chk("p_lockout", 32'(lockout), 1);
    chk("p_alarm", 32'(alarm), 0);
    repeat (19) @(negedge clk);
    chk("p_on19", 32'(lockout), 1);
    @(negedge clk);
    chk("p_off20", 32'(lockout), 0);

    // second consecutive lockout escalates to alarm, held until reset
    strobe(1'b0); strobe(1'b0); strobe(1'b0);
    chk("al_alarm", 32'(alarm), 1);
    chk("al_lockout", 32'(lockout), 1);
    chk("al_remain", 32'(remain), 0);
    errs = 0; pulses = 0;
    for (int i = 0; i < 100; i++) begin
      ent = ~ent;
      if (i == 50) begin check_valid = 1'b1; check_pass = 1'b1; end
      @(negedge clk);
      check_valid = 1'b0; check_pass = 1'b0;
      if (!alarm || !lockout || remain != 6'd0) errs++;
      pulses += int'(ent_p | clr_p | change_p);
    end
    chk("al_hold", 32'(errs), 0);
    chk("al_no_pulses", 32'(pulses), 0);
    ent = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("al_rst");
    rst = 1'b1;
    @(negedge clk);

    // reset mid-lockout, then lockout count must have been cleared
    strobe(1'b0); strobe(1'b0); strobe(1'b0);
    chk("m_lockout", 32'(lockout), 1);
    repeat (10) @(negedge clk);
    chk("m_rem1", 32'(remain), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("m_rst_lockout", 32'(lockout), 0);
    chk("m_rst_remain", 32'(remain), 0);
    rst = 1'b1;
    @(negedge clk);
    strobe(1'b0); strobe(1'b0); strobe(1'b0);
    chk("m2_lockout", 32'(lockout), 1);
    chk("m2_alarm", 32'(alarm), 0);
    chk("m2_remain", 32'(remain), 2);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
